// File: rtl/goal_detect_if.sv
// rtl/goal_detect_if.sv - ball position, serve and point signals between ball motion, goal_detect and score keeper
interface goal_detect_if #(
  parameter int X_W = 10
);
  logic           frame_tick;
  logic [X_W-1:0] ball_x;
  logic           ball_dir_left;
  logic           serve_btn;
  logic           game_over;
  logic           p1_win;
  logic           p2_win;
  logic           ball_reset;
  logic           serve;
  logic           serve_dir_left;
  logic [2:0]     state_dbg;

  modport master (
    output frame_tick, ball_x, ball_dir_left, serve_btn, game_over,
    input  p1_win, p2_win, ball_reset, serve, serve_dir_left, state_dbg
  );

  modport slave (
    input  frame_tick, ball_x, ball_dir_left, serve_btn, game_over,
    output p1_win, p2_win, ball_reset, serve, serve_dir_left, state_dbg
  );
endinterface

// File: rtl/goal_detect.sv
// rtl/goal_detect.sv - point detection, post-point ball hold and serve gating
// Optional AUTO_SERVE_EN: after the first button serve, later serves fire automatically.
module goal_detect #(
  parameter int X_W          = 10,
  parameter int LEFT_GOAL_X  = 0,
  parameter int RIGHT_GOAL_X = 632,
  parameter int HOLD_FRAMES  = 60,
  parameter int CNT_W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  goal_detect_if.slave bus
);

  typedef enum logic [2:0] {
    SERVE_WAIT = 3'd0,
    PLAY       = 3'd1,
    P1_PT      = 3'd2,
    P2_PT      = 3'd3,
    HOLD       = 3'd4,
    HALT       = 3'd5
  } state_t;

  localparam logic [X_W-1:0]   LEFT_X   = X_W'(LEFT_GOAL_X);
  localparam logic [X_W-1:0]   RIGHT_X  = X_W'(RIGHT_GOAL_X);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_FRAMES);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             btn_q;
  logic             armed;
  logic             btn_rise;
  logic             start_serve;
  logic             at_left, at_right;

  // armed stays low until the button has been seen released, so a press held through reset never serves
  assign btn_rise = bus.serve_btn & ~btn_q & armed;
  assign at_left  = bus.ball_dir_left & (bus.ball_x <= LEFT_X);
  assign at_right = ~bus.ball_dir_left & (bus.ball_x >= RIGHT_X);
  assign cnt_inc  = cnt + CNT_W'(1);

`ifdef AUTO_SERVE_EN
  logic served_once;

  assign start_serve = served_once | btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      served_once <= 1'b0;
    end else if (state == SERVE_WAIT && state_next == PLAY) begin
      served_once <= 1'b1;
    end
  end
`else
  assign start_serve = btn_rise;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      SERVE_WAIT: begin
        if (start_serve) state_next = PLAY;
      end
      PLAY: begin
        if (bus.game_over)                  state_next = HALT;
        else if (bus.frame_tick && at_left)  state_next = P2_PT;
        else if (bus.frame_tick && at_right) state_next = P1_PT;
      end
      P1_PT, P2_PT: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        if (bus.game_over) begin
          state_next = HALT;
        end else if (bus.frame_tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == HOLD_CNT) state_next = SERVE_WAIT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = SERVE_WAIT;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_dbg
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= SERVE_WAIT;
      cnt                <= '0;
      btn_q              <= 1'b0;
      armed              <= ~bus.serve_btn;
      bus.p1_win         <= 1'b0;
      bus.p2_win         <= 1'b0;
      bus.serve          <= 1'b0;
      bus.ball_reset     <= 1'b1;
      bus.serve_dir_left <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      btn_q          <= bus.serve_btn;
      if (!bus.serve_btn) armed <= 1'b1;
      bus.p1_win     <= (state_next == P1_PT);
      bus.p2_win     <= (state_next == P2_PT);
      bus.serve      <= (state == SERVE_WAIT) && (state_next == PLAY);
      bus.ball_reset <= (state_next != PLAY);
      if (state_next == P1_PT)      bus.serve_dir_left <= 1'b0;
      else if (state_next == P2_PT) bus.serve_dir_left <= 1'b1;
    end
  end

  assign bus.state_dbg = state;

endmodule

// File: tb/tb_goal_detect.sv
// tb/tb_goal_detect.sv - vector table, directed corner sequences and random run against a rally model
module tb_goal_detect;

  localparam int HOLD  = 3;
  localparam int LEFT  = 0;
  localparam int RIGHT = 632;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  goal_detect_if #(.X_W(10)) bus ();

  goal_detect #(
    .X_W(10), .LEFT_GOAL_X(LEFT), .RIGHT_GOAL_X(RIGHT), .HOLD_FRAMES(HOLD), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         tick;
    int         x;
    bit         dl;
    bit         btn;
    bit         go;
    int         reps;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Rally model: ball live, pending point, frames left to hold, halted
  bit m_live, m_halt, m_prev_btn, m_seen_low, m_served, m_serve, m_dir;
  int m_point;
  int m_hold;

  function automatic logic [7:0] pk(bit p1, bit p2, bit br, bit sv, bit dir, int st);
    logic [2:0] s;
    s = 3'(st);
    return {p1, p2, br, sv, dir, s};
  endfunction

  function automatic vec_t mk(bit r, bit t, int x, bit dl, bit b, bit g, int reps,
                              bit p1, bit p2, bit br, bit sv, bit dir, int st);
    vec_t v;
    v.rst = r; v.tick = t; v.x = x; v.dl = dl; v.btn = b; v.go = g; v.reps = reps;
    v.exp = pk(p1, p2, br, sv, dir, st);
    return v;
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.p1_win, bus.p2_win, bus.ball_reset, bus.serve, bus.serve_dir_left, bus.state_dbg};
  endfunction

  function automatic logic [7:0] mdl_out();
    int st;
    if (m_halt)            st = 5;
    else if (m_point == 1) st = 2;
    else if (m_point == 2) st = 3;
    else if (m_hold > 0)   st = 4;
    else if (m_live)       st = 1;
    else                   st = 0;
    return pk(m_point == 1, m_point == 2, !m_live, m_serve, m_dir, st);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got p1,p2,br,sv,dir,st=%b required %b", name, $time, act, req);
    end
  endtask

  task automatic drv(bit r, bit t, int x, bit dl, bit b, bit g);
    rst               = r;
    bus.frame_tick    = t;
    bus.ball_x        = 10'(x);
    bus.ball_dir_left = dl;
    bus.serve_btn     = b;
    bus.game_over     = g;
  endtask

  task automatic model_step();
    bit rise;
    bit auto_ok;
`ifdef AUTO_SERVE_EN
    auto_ok = m_served;
`else
    auto_ok = 1'b0;
`endif
    if (rst) begin
      m_live = 0; m_halt = 0; m_point = 0; m_hold = 0; m_serve = 0; m_dir = 0;
      m_prev_btn = 0; m_seen_low = !bus.serve_btn; m_served = 0;
      return;
    end
    rise       = bus.serve_btn && !m_prev_btn && m_seen_low;
    m_prev_btn = bus.serve_btn;
    if (!bus.serve_btn) m_seen_low = 1;
    m_serve = 0;
    if (m_halt) begin
    end else if (m_point != 0) begin
      m_point = 0;
      m_hold  = HOLD;
    end else if (m_hold > 0) begin
      if (bus.game_over) begin
        m_hold = 0;
        m_halt = 1;
      end else if (bus.frame_tick) begin
        m_hold--;
      end
    end else if (m_live) begin
      if (bus.game_over) begin
        m_live = 0;
        m_halt = 1;
      end else if (bus.frame_tick && bus.ball_dir_left && int'(bus.ball_x) <= LEFT) begin
        m_live = 0; m_point = 2; m_dir = 1;
      end else if (bus.frame_tick && !bus.ball_dir_left && int'(bus.ball_x) >= RIGHT) begin
        m_live = 0; m_point = 1; m_dir = 0;
      end
    end else if (rise || auto_ok) begin
      m_live   = 1;
      m_serve  = 1;
      m_served = 1;
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_out(), mdl_out());
  endtask

  task automatic expect_st(input string name, input int st);
    logic [2:0] s;
    s = 3'(st);
    check(name, {5'b0, bus.state_dbg}, {5'b0, s});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    drv(1, 0, 0, 0, 1, 0);

    //          rst tk x    dl btn go reps  p1 p2 br sv dir st
    tbl.push_back(mk(1, 0, 0,   0, 1, 0, 2,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 3,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 1,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 1,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 632, 0, 0, 0, 2,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 632, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 632, 0, 0, 0, 1,   1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 632, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 1, 632, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 632, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 1, 632, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 1, 632, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 1,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,   1, 0, 0, 10,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,   1, 0, 0, 1,   0, 1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0,   1, 0, 0, 1,   0, 0, 1, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0,   1, 0, 0, 1,   0, 0, 1, 0, 1, 4));
    tbl.push_back(mk(1, 0, 0,   1, 0, 0, 1,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 1, 0, 1,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 632, 0, 0, 1, 1,   0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 1, 632, 0, 1, 0, 3,   0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1,   0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0, 1,   0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0,   0, 0, 0, 1,   0, 0, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drv(tbl[i].rst, tbl[i].tick, tbl[i].x, tbl[i].dl, tbl[i].btn, tbl[i].go);
        step("model");
        check($sformatf("table_row%0d", i), dut_out(), tbl[i].exp);
      end
    end

    // game_over during the post-point hold halts the game
    drv(0, 0, 0, 0, 1, 0); step("halt_serve"); expect_st("halt_serve_st", 1);
    drv(0, 1, 700, 0, 0, 0); step("halt_goal"); expect_st("halt_goal_st", 2);
    drv(0, 0, 700, 0, 0, 0); step("halt_hold"); expect_st("halt_hold_st", 4);
    drv(0, 0, 700, 0, 0, 1); step("halt_go"); expect_st("halt_go_st", 5);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, i[0], i[0], 0);
      step("halt_stay");
      expect_st("halt_stay_st", 5);
    end

    // Second rally: serve after the hold is automatic only with AUTO_SERVE_EN
    drv(1, 0, 0, 0, 0, 0); step("auto_rst");
    drv(0, 0, 0, 0, 1, 0); step("auto_serve1"); expect_st("auto_serve1_st", 1);
    drv(0, 1, 0, 1, 0, 0); step("auto_goal"); expect_st("auto_goal_st", 3);
    for (int i = 0; i < HOLD + 1; i++) begin
      drv(0, 1, 0, 1, 0, 0);
      step("auto_hold");
    end
    expect_st("auto_hold_done", 0);
    drv(0, 0, 0, 1, 0, 0); step("auto_next");
`ifdef AUTO_SERVE_EN
    check("auto_serve2", dut_out(), pk(0, 0, 0, 1, 1, 1));
`else
    check("no_auto_serve", dut_out(), pk(0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step("wait_btn");
      expect_st("wait_btn_st", 0);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      int sel;
      int x;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       x = 0;
        1:       x = 1;
        2:       x = 631;
        3:       x = 632;
        4:       x = 1023;
        default: x = int'($urandom_range(0, 1023));
      endcase
      drv($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          x,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? !bus.serve_btn : bus.serve_btn,
          $urandom_range(0, 149) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/goal_detect.md
Name: goal_detect

Overview:
- Upstream stage of the score keeper: watches ball position once per video frame and decides when a point has been won.
- Issues one-cycle p1_win / p2_win pulses to the scoring FSM, then holds the ball in reset for a fixed number of frames and gates the next serve.
- Sits between the ball-motion block (supplies ball_x, direction, frame tick) and the score keeper (consumes win pulses, returns game_over).

Parameters:
- X_W, 10, width of ball_x
- LEFT_GOAL_X, 0, ball_x at or below this while moving left = ball out on left
- RIGHT_GOAL_X, 632, ball_x at or above this while moving right = ball out on right
- HOLD_FRAMES, 60, frame ticks ball_reset stays high after a point (must be >= 1)
- CNT_W, 8, width of hold counter (must hold HOLD_FRAMES)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame; only cycles where ball position is sampled
- ball_x  in  X_W  ball left-edge x coordinate
- ball_dir_left  in  1  1 = ball moving toward left wall
- serve_btn  in  1  serve request, level, already debounced
- game_over  in  1  from score keeper; freezes point detection
- p1_win  out  1  one-cycle pulse: player 1 scored (ball out on right)
- p2_win  out  1  one-cycle pulse: player 2 scored (ball out on left)
- ball_reset  out  1  hold ball at centre, motion disabled
- serve  out  1  one-cycle pulse: ball released
- serve_dir_left  out  1  direction of next serve (toward player who conceded)
- state_dbg  out  3  current state encoding

Behaviour:
- All outputs registered. Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: p1_win=0, p2_win=0, serve=0, ball_reset=1, serve_dir_left=0, state=SERVE_WAIT, hold counter=0, serve_btn edge register=0.
- States: SERVE_WAIT(0), PLAY(1), P1_PT(2), P2_PT(3), HOLD(4), HALT(5).
- SERVE_WAIT: ball_reset=1. Rising edge of serve_btn (sampled vs previous cycle) -> serve=1 for one cycle, ball_reset=0 the same cycle, go PLAY. Button held high through reset does not serve; a fresh 0->1 edge is required.
- PLAY: ball_reset=0. Only on a frame_tick cycle:
  - ball_dir_left=1 and ball_x <= LEFT_GOAL_X -> P2_PT.
  - ball_dir_left=0 and ball_x >= RIGHT_GOAL_X -> P1_PT.
  - No transition on non-tick cycles.
- P1_PT / P2_PT: exactly one cycle. Assert the corresponding win output for that one cycle only. Set ball_reset=1. Set serve_dir_left=0 after P1_PT and 1 after P2_PT (serve toward conceding player). Clear hold counter. Go HOLD.
- HOLD: ball_reset=1. Increment counter on each frame_tick. On the tick that brings the count to HOLD_FRAMES:
  - game_over=1 -> HALT.
  - otherwise -> SERVE_WAIT.
- game_over checked in PLAY and HOLD; when high, go HALT next cycle. In PLAY, game_over takes priority over a same-cycle goal: no pulse issued.
- HALT: ball_reset=1, no pulses. Exit only by rst.
- Win pulses never overlap, and are always >= HOLD_FRAMES+1 frames apart. The downstream FSM relies on both wins being low between points.
- serve_btn edges are ignored outside SERVE_WAIT. The edge register still tracks, so a held button does not fire on entry.
- Reset mid-HOLD or mid-pulse: the pulse is dropped and the FSM returns to SERVE_WAIT with ball_reset=1.
- Counter compare is an equality at HOLD_FRAMES. The counter must never wrap.

Optional Feature:
- Macro AUTO_SERVE_EN.
- Defined: SERVE_WAIT does not wait for serve_btn. One cycle after entry, serve pulses and the FSM goes PLAY. Direction comes from serve_dir_left. serve_btn is used only for the very first serve after reset.
- Undefined: every serve requires a serve_btn rising edge, as above.

Test Plan:
- Reset with serve_btn=1 held -> no serve. Release and re-press -> serve=1 for exactly 1 cycle, ball_reset falls, state_dbg=1.
- PLAY, ball_x=632, ball_dir_left=0, frame_tick pulse -> p1_win=1 for exactly 1 cycle, p2_win=0, serve_dir_left=0, ball_reset=1. With HOLD_FRAMES=3, state_dbg=0 after the 3rd subsequent tick.
- PLAY, ball_x=0, ball_dir_left=1, no frame_tick for 10 cycles -> no pulse. Then tick -> p2_win single pulse, serve_dir_left=1.
- PLAY, ball_x=632 but ball_dir_left=1 on a tick -> no pulse, stays PLAY.
- game_over=1 in the same cycle as a goal tick -> no win pulse, state_dbg=5. Serve presses ignored until rst.
- rst asserted in HOLD after 1 of 3 ticks -> next cycle state_dbg=0, ball_reset=1, no win pulse. With AUTO_SERVE_EN, a point on the second rally auto-serves 1 cycle after HOLD completes.
